alu_operand_stage: RTL
======================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width in bits.
REQ-002 Parameter IMM_W, 16, immediate field width; SHALL be less than DATA_W.
REQ-003 Parameter REG_AW, 5, register address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  decode-stage operands present this cycle.
REQ-007 rs_addr, rt_addr  input  REG_AW each  source register numbers.
REQ-008 rs_data, rt_data  input  DATA_W each  register-file read values.
REQ-009 imm  input  IMM_W  raw immediate field.
REQ-010 imm_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper (imm placed in the top IMM_W bits, low bits zero), 11 treated as 00.
REQ-011 alu_src  input  1  0 selects forwarded rt for ALU B; 1 selects the extended immediate.
REQ-012 exm_wr_en, exm_wr_addr, exm_wr_data  input  1/REG_AW/DATA_W  EX/MEM writeback candidate.
REQ-013 mwb_wr_en, mwb_wr_addr, mwb_wr_data  input  1/REG_AW/DATA_W  MEM/WB writeback candidate.
REQ-014 stall  input  1  hold all registered state.
REQ-015 flush  input  1  kill the operand held in the stage.
REQ-016 out_valid  output  1  registered operands valid.
REQ-017 alu_a, alu_b, store_data  output  DATA_W each  registered ALU A, ALU B and forwarded rt.
REQ-018 fwd_a_sel, fwd_b_sel  output  2 each  registered source code: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-019 fwd_count  output  16  saturating count of accepted operands that used at least one forward.

Function
REQ-020 Forwarded rs: EX/MEM data if exm_wr_en and exm_wr_addr==rs_addr; else MEM/WB data if mwb_wr_en and mwb_wr_addr==rs_addr; else rs_data.
REQ-021 Forwarded rt: same rule using rt_addr.
REQ-022 Register address 0 SHALL never be forwarded; source code 00 and regfile data are used.
REQ-023 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-024 Extended immediate per imm_mode, computed combinationally, width exactly DATA_W.
REQ-025 ALU B = alu_src ? extended immediate : forwarded rt; store_data = forwarded rt regardless of alu_src.
REQ-026 fwd_b_sel SHALL report the rt forward source even when alu_src=1.
REQ-027 Latency is one cycle: inputs accepted on edge N appear on outputs after edge N.
REQ-028 Accept condition: in_valid=1, stall=0, flush=0; on accept, all data and select registers load and out_valid becomes 1.
REQ-029 stall=1, flush=0: every register, including out_valid and fwd_count, holds.
REQ-030 flush=1: out_valid cleared next edge regardless of stall or in_valid; data registers hold; fwd_count does not increment.
REQ-031 in_valid=0, stall=0, flush=0: out_valid cleared; data and select registers hold.
REQ-032 fwd_count increments by 1 on an accept where fwd_a_sel or fwd_b_sel next value is non-zero; saturates at 0xFFFF.

Reset
REQ-033 rst_n low SHALL immediately clear out_valid, alu_a, alu_b, store_data, fwd_a_sel, fwd_b_sel and fwd_count to zero, independent of clk.
REQ-034 Reset asserted mid-stall or mid-flush SHALL still force all zeros; the first accept after rst_n rises behaves normally.

Verification
REQ-035 rs=3, rt=4, no forward matches, rs_data=0x11, rt_data=0x22, alu_src=0 -> next cycle alu_a=0x11, alu_b=0x22, sels 00/00, fwd_count unchanged.
REQ-036 rs=3, exm_wr_addr=3 data 0xAA, mwb_wr_addr=3 data 0xBB, both enabled -> alu_a=0xAA, fwd_a_sel=01, fwd_count+1; same with rs=0 -> alu_a=rs_data, sel 00.
REQ-037 imm=0x8001, alu_src=1: mode 00 -> alu_b=0xFFFF8001; 01 -> 0x00008001; 10 -> 0x80010000; 11 -> 0xFFFF8001; store_data equals forwarded rt in each case.
REQ-038 Accept, then stall 3 cycles with changing inputs -> outputs frozen; stall+flush together -> out_valid=0 next cycle, data unchanged.
REQ-039 Preload fwd_count to 0xFFFE via 0xFFFE forwarded accepts, apply 2 more -> 0xFFFF and stays; assert rst_n low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_operand_if.sv
// Operand bundle between decode and the ALU operand stage.
// Carries decode operands, writeback candidates and registered results.
interface alu_operand_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [IMM_W-1:0]  imm;
  logic [1:0]        imm_mode;
  logic              alu_src;
  logic              exm_wr_en;
  logic [REG_AW-1:0] exm_wr_addr;
  logic [DATA_W-1:0] exm_wr_data;
  logic              mwb_wr_en;
  logic [REG_AW-1:0] mwb_wr_addr;
  logic [DATA_W-1:0] mwb_wr_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] store_data;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [15:0]       fwd_count;

  modport master (
    output in_valid, rs_addr, rt_addr, rs_data, rt_data,
    output imm, imm_mode, alu_src,
    output exm_wr_en, exm_wr_addr, exm_wr_data,
    output mwb_wr_en, mwb_wr_addr, mwb_wr_data,
    output stall, flush,
    input  out_valid, alu_a, alu_b, store_data,
    input  fwd_a_sel, fwd_b_sel, fwd_count
  );

  modport slave (
    input  in_valid, rs_addr, rt_addr, rs_data, rt_data,
    input  imm, imm_mode, alu_src,
    input  exm_wr_en, exm_wr_addr, exm_wr_data,
    input  mwb_wr_en, mwb_wr_addr, mwb_wr_data,
    input  stall, flush,
    output out_valid, alu_a, alu_b, store_data,
    output fwd_a_sel, fwd_b_sel, fwd_count
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarding muxes, immediate extension and
// one-cycle operand register with stall/flush and forward counter.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5
) (
  input logic         clk,
  input logic         rst_n,
  alu_operand_if.slave bus
);

  localparam logic [1:0] SRC_RF  = 2'b00;
  localparam logic [1:0] SRC_EXM = 2'b01;
  localparam logic [1:0] SRC_MWB = 2'b10;
  localparam int         PAD_W   = DATA_W - IMM_W;

  typedef struct packed {
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } fwd_t;

  function automatic fwd_t fwd(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              exm_en,
    input logic [REG_AW-1:0] exm_addr,
    input logic [DATA_W-1:0] exm_data,
    input logic              mwb_en,
    input logic [REG_AW-1:0] mwb_addr,
    input logic [DATA_W-1:0] mwb_data
  );
    fwd_t r;
    logic hit_exm;
    logic hit_mwb;
    // r0 is hardwired; EX/MEM wins over MEM/WB
    hit_exm = exm_en && (exm_addr == addr) && (addr != '0);
    hit_mwb = !hit_exm && mwb_en && (mwb_addr == addr) && (addr != '0);
    r.sel  = SRC_RF;
    r.data = rf_data;
    unique case (1'b1)
      hit_exm: begin
        r.sel  = SRC_EXM;
        r.data = exm_data;
      end
      hit_mwb: begin
        r.sel  = SRC_MWB;
        r.data = mwb_data;
      end
      default: ;
    endcase
    return r;
  endfunction

  fwd_t              fa;
  fwd_t              fb;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] b_next;
  logic              accept;
  logic              fwd_any;

  always_comb begin
    fa = fwd(bus.rs_addr, bus.rs_data,
             bus.exm_wr_en, bus.exm_wr_addr, bus.exm_wr_data,
             bus.mwb_wr_en, bus.mwb_wr_addr, bus.mwb_wr_data);
    fb = fwd(bus.rt_addr, bus.rt_data,
             bus.exm_wr_en, bus.exm_wr_addr, bus.exm_wr_data,
             bus.mwb_wr_en, bus.mwb_wr_addr, bus.mwb_wr_data);
  end

  always_comb begin
    imm_ext = {{PAD_W{bus.imm[IMM_W-1]}}, bus.imm};
    unique case (1'b1)
      (bus.imm_mode == 2'b01): imm_ext = {{PAD_W{1'b0}}, bus.imm};
      (bus.imm_mode == 2'b10): imm_ext = {bus.imm, {PAD_W{1'b0}}};
      default: ;
    endcase
  end

  assign b_next  = bus.alu_src ? imm_ext : fb.data;
  assign accept  = bus.in_valid && !bus.stall && !bus.flush;
  assign fwd_any = (fa.sel != SRC_RF) || (fb.sel != SRC_RF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.store_data <= '0;
      bus.fwd_a_sel  <= SRC_RF;
      bus.fwd_b_sel  <= SRC_RF;
      bus.fwd_count  <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid <= bus.in_valid;
      if (accept) begin
        bus.alu_a      <= fa.data;
        bus.alu_b      <= b_next;
        bus.store_data <= fb.data;
        bus.fwd_a_sel  <= fa.sel;
        bus.fwd_b_sel  <= fb.sel;
        if (fwd_any && (bus.fwd_count != 16'hFFFF))
          bus.fwd_count <= bus.fwd_count + 16'd1;
      end
    end
  end

endmodule
